// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry valid/ready pipeline register with hazard hold, flush, and bubble control zeroing.
// Saturating stall/flush/backpressure counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bp_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_r;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic              push_s;
    logic              pop_s;

    // Handshake outputs and transfer events; control is zeroed on any bubble
    always_comb begin
        in_ready  = (state_r != TWO) && !hold;
        out_valid = (state_r != EMPTY) && !hold;
        out_data  = main_data_r;
        if (out_valid) begin
            out_ctrl = main_ctrl_r;
        end else begin
            out_ctrl = {CTRL_W{1'b0}};
        end
        push_s = in_valid && in_ready && !flush;
        pop_s  = out_valid && out_ready;
    end

    // Occupancy state and entry storage; flush empties and kills control but keeps payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else if (flush) begin
            state_r     <= EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        state_r     <= ONE;
                        main_data_r <= in_data;
                        main_ctrl_r <= in_ctrl;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        main_data_r <= in_data;
                        main_ctrl_r <= in_ctrl;
                    end else if (push_s) begin
                        state_r     <= TWO;
                        skid_data_r <= in_data;
                        skid_ctrl_r <= in_ctrl;
                    end else if (pop_s) begin
                        state_r <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move the skid entry forward
                    if (pop_s) begin
                        state_r     <= ONE;
                        main_data_r <= skid_data_r;
                        main_ctrl_r <= skid_ctrl_r;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] bp_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
            bp_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (hold) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush && (state_r != EMPTY)) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
            if (out_valid && !out_ready) begin
                bp_cnt_r <= sat_inc(bp_cnt_r);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign bp_cnt    = bp_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
    assign bp_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        hold;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] bp_cnt;

    logic        sm_in_ready;
    logic        sm_out_valid;
    logic [7:0]  sm_out_data;
    logic [3:0]  sm_out_ctrl;
    logic [3:0]  sm_stall_cnt;
    logic [3:0]  sm_flush_cnt;
    logic [3:0]  sm_bp_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of accepted entries plus event counts
    logic [63:0] qd[$];
    logic [15:0] qc[$];
    int m_stall, m_flush, m_bp;

    logic        e_in_ready, e_out_valid;
    logic [63:0] e_data;
    logic [15:0] e_ctrl, e_stall, e_flush, e_bp;
    logic [3:0]  e_sm_stall, e_sm_flush, e_sm_bp;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .bp_cnt(bp_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sm_in_ready),
        .in_data(in_data[7:0]), .in_ctrl(in_ctrl[3:0]), .hold(hold), .flush(flush),
        .out_valid(sm_out_valid), .out_ready(out_ready), .out_data(sm_out_data),
        .out_ctrl(sm_out_ctrl), .stall_cnt(sm_stall_cnt), .flush_cnt(sm_flush_cnt),
        .bp_cnt(sm_bp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    function automatic void calc_exp();
        e_in_ready  = (qd.size() < 2) && !hold;
        e_out_valid = (qd.size() > 0) && !hold;
        e_data      = (qd.size() > 0) ? qd[0] : 64'd0;
        e_ctrl      = e_out_valid ? qc[0] : 16'd0;
        e_stall     = PERF ? 16'(m_stall) : 16'd0;
        e_flush     = PERF ? 16'(m_flush) : 16'd0;
        e_bp        = PERF ? 16'(m_bp) : 16'd0;
        e_sm_stall  = PERF ? sat4(m_stall) : 4'd0;
        e_sm_flush  = PERF ? sat4(m_flush) : 4'd0;
        e_sm_bp     = PERF ? sat4(m_bp) : 4'd0;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT
    task automatic tick();
        logic push_v, pop_v;
        calc_exp();
        push_v = in_valid && e_in_ready && !flush;
        pop_v  = e_out_valid && out_ready;
        if (hold && m_stall < 65535) m_stall++;
        if (flush && qd.size() > 0 && m_flush < 65535) m_flush++;
        if (e_out_valid && !out_ready && m_bp < 65535) m_bp++;
        if (flush) begin
            qd.delete();
            qc.delete();
        end else begin
            if (pop_v) begin
                void'(qd.pop_front());
                void'(qc.pop_front());
            end
            if (push_v) begin
                qd.push_back(in_data);
                qc.push_back(in_ctrl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = 64'd0; in_ctrl = 16'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qd.delete(); qc.delete();
        m_stall = 0; m_flush = 0; m_bp = 0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = 64'd0; in_ctrl = 16'd0;
        rst = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
        checks++; if (out_ctrl !== 16'd0) begin errors++; $display("FAIL reset_out_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
        checks++; if ({stall_cnt, flush_cnt, bp_cnt} !== 48'd0) begin errors++; $display("FAIL reset_counters: got %0h expected 0", {stall_cnt, flush_cnt, bp_cnt}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        qd.delete(); qc.delete();
        m_stall = 0; m_flush = 0; m_bp = 0;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            in_data  = 64'(i + 1);
            in_ctrl  = 16'h00FF;
            @(negedge clk);
            calc_exp();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc%0d: got %0h expected 1", i, in_ready); end
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL stream_out_valid cyc%0d: got %0h expected %0h", i, out_valid, e_out_valid); end
            checks++; if (out_ctrl !== e_ctrl) begin errors++; $display("FAIL stream_out_ctrl cyc%0d: got %0h expected %0h", i, out_ctrl, e_ctrl); end
            if (e_out_valid) begin
                checks++; if (out_data !== 64'(i)) begin errors++; $display("FAIL stream_out_data cyc%0d: got %0h expected %0h", i, out_data, i); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] src [3];
        logic [63:0] got[$];
        int idx;
        src[0] = 64'hA; src[1] = 64'hB; src[2] = 64'hC;
        idx = 0;
        do_reset();
        in_ctrl = 16'h0101;
        for (int c = 0; c < 7; c++) begin
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? src[idx] : 64'd0;
            out_ready = (c >= 3);
            @(negedge clk);
            calc_exp();
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %0h expected %0h", c, in_ready, e_in_ready); end
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %0h expected 0", in_ready); end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && e_in_ready) idx++;
            tick();
        end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            checks++; if (got[k] !== src[k]) begin errors++; $display("FAIL bp_order[%0d]: got %0h expected %0h", k, got[k], src[k]); end
        end
        checks++; if (bp_cnt !== (PERF ? 16'd2 : 16'd0)) begin errors++; $display("FAIL bp_cnt: got %0d expected %0d", bp_cnt, PERF ? 2 : 0); end
    endtask

    task automatic test_hold();
        int seen;
        seen = 0;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h7; in_ctrl = 16'h0003;
        tick();
        in_valid = 1'b0;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL hold_valid_ready cyc%0d: got %0b expected 00", c, {out_valid, in_ready}); end
            checks++; if (out_ctrl !== 16'd0) begin errors++; $display("FAIL hold_out_ctrl cyc%0d: got %0h expected 0", c, out_ctrl); end
            tick();
        end
        hold = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_data == 64'h7) begin
                seen++;
                checks++; if (out_ctrl !== 16'h0003) begin errors++; $display("FAIL hold_release_ctrl: got %0h expected 3", out_ctrl); end
            end
            tick();
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL hold_once: got %0d expected 1", seen); end
        checks++; if (stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin errors++; $display("FAIL hold_stall_cnt: got %0d expected %0d", stall_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_flush();
        do_reset();
        in_ctrl = 16'h00F0;
        in_valid = 1'b1; in_data = 64'h10; tick();
        in_data = 64'h11; tick();
        in_data = 64'h12; flush = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %0h expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({out_valid, out_ctrl} !== 17'd0) begin errors++; $display("FAIL flush_bubble cyc%0d: got %0h expected 0", c, {out_valid, out_ctrl}); end
            tick();
        end
        checks++; if (out_data !== 64'h10) begin errors++; $display("FAIL flush_data_kept: got %0h expected 10", out_data); end
        checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, PERF ? 1 : 0); end
        flush = 1'b1; tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL flush_empty_cnt: got %0d expected %0d", flush_cnt, PERF ? 1 : 0); end
        tick();
    endtask

    task automatic test_flush_hold();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h20; in_ctrl = 16'h0005; tick();
        in_valid = 1'b0; hold = 1'b1; flush = 1'b1; tick();
        hold = 1'b0; flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_hold cyc%0d: got %0b expected 01", c, {out_valid, in_ready}); end
            checks++; if (out_ctrl !== 16'd0) begin errors++; $display("FAIL flush_hold_ctrl cyc%0d: got %0h expected 0", c, out_ctrl); end
            tick();
        end
        checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL flush_hold_cnt: got %0d expected %0d", flush_cnt, PERF ? 1 : 0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_ctrl = 16'h0033;
        in_valid = 1'b1; in_data = 64'h30; tick();
        in_data = 64'h31; tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_pre_full: got %0h expected 0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL areset_immediate: got %0b expected 01", {out_valid, in_ready}); end
        checks++; if ({stall_cnt, flush_cnt, bp_cnt} !== 48'd0) begin errors++; $display("FAIL areset_counters: got %0h expected 0", {stall_cnt, flush_cnt, bp_cnt}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        qd.delete(); qc.delete();
        m_stall = 0; m_flush = 0; m_bp = 0;
        hold = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        hold = 1'b0;
        @(negedge clk);
        checks++; if (sm_stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_stall_cnt: got %0d expected %0d", sm_stall_cnt, PERF ? 15 : 0); end
        checks++; if (stall_cnt !== (PERF ? 16'd20 : 16'd0)) begin errors++; $display("FAIL wide_stall_cnt: got %0d expected %0d", stall_cnt, PERF ? 20 : 0); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = {$urandom, $urandom};
            in_ctrl   = 16'($urandom);
            @(negedge clk);
            calc_exp();
            checks++; if ({in_ready, out_valid} !== {e_in_ready, e_out_valid}) begin errors++; $display("FAIL rnd_handshake cyc%0d: got %0b expected %0b", c, {in_ready, out_valid}, {e_in_ready, e_out_valid}); end
            checks++; if (out_ctrl !== e_ctrl) begin errors++; $display("FAIL rnd_ctrl cyc%0d: got %0h expected %0h", c, out_ctrl, e_ctrl); end
            if (e_out_valid) begin
                checks++; if (out_data !== e_data) begin errors++; $display("FAIL rnd_data cyc%0d: got %0h expected %0h", c, out_data, e_data); end
                checks++; if ({sm_out_data, sm_out_ctrl} !== {e_data[7:0], e_ctrl[3:0]}) begin errors++; $display("FAIL rnd_small_out cyc%0d: got %0h expected %0h", c, {sm_out_data, sm_out_ctrl}, {e_data[7:0], e_ctrl[3:0]}); end
            end
            checks++; if ({sm_in_ready, sm_out_valid} !== {e_in_ready, e_out_valid}) begin errors++; $display("FAIL rnd_small_hs cyc%0d: got %0b expected %0b", c, {sm_in_ready, sm_out_valid}, {e_in_ready, e_out_valid}); end
            checks++; if ({stall_cnt, flush_cnt, bp_cnt} !== {e_stall, e_flush, e_bp}) begin errors++; $display("FAIL rnd_counters cyc%0d: got %0h expected %0h", c, {stall_cnt, flush_cnt, bp_cnt}, {e_stall, e_flush, e_bp}); end
            checks++; if ({sm_stall_cnt, sm_flush_cnt, sm_bp_cnt} !== {e_sm_stall, e_sm_flush, e_sm_bp}) begin errors++; $display("FAIL rnd_small_counters cyc%0d: got %0h expected %0h", c, {sm_stall_cnt, sm_flush_cnt, sm_bp_cnt}, {e_sm_stall, e_sm_flush, e_sm_bp}); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_hold();
        test_flush();
        test_flush_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the ID/EX boundary. It generalises the fixed-field latch into a two-entry buffer.
- Separates a payload bus (register data, immediates, PC) from a control bus (write enables, ALU op, branch/jump flags).
- Adds a valid/ready handshake, a hazard hold, flush/squash, and zeroing of control bits on bubbles, so a killed instruction can never write the register file or memory.
- Reusable at IF/ID, EX/MEM and MEM/WB by changing the parameters.

Parameters:
DATA_W, 64, payload width; not cleared on a bubble.
CTRL_W, 16, control width; forced to 0 whenever out_valid=0.
CNT_W, 16, width of the performance counters (used only with PIPE_STAGE_PERF_EN).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  upstream stage presents an instruction
in_ready  out  1  stage can accept; depends only on registered state and hold, never on out_ready
in_data  in  DATA_W  payload from upstream
in_ctrl  in  CTRL_W  control bits from upstream
hold  in  1  hazard stall; freezes the stage
flush  in  1  squash every held instruction (branch/jr/jal redirect)
out_valid  out  1  instruction presented to the next stage
out_ready  in  1  next stage accepts
out_data  out  DATA_W  payload of the head entry
out_ctrl  out  CTRL_W  head control bits, or 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with hold=1
flush_cnt  out  CNT_W  flush events that killed at least one valid entry
bp_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage:
  - main entry (head) and skid entry, each holding DATA_W+CTRL_W bits.
  - 2-bit occupancy state: EMPTY=0, ONE=1, TWO=2.
- Reset (async, rst=1): state EMPTY; main and skid data/ctrl = 0; counters = 0. Therefore out_valid=0, out_ctrl=0, out_data=0, in_ready=1 (while hold=0).
- Combinational outputs:
  - in_ready = (state!=TWO) & ~hold.
  - out_valid = (state!=EMPTY) & ~hold.
  - out_data = main data.
  - out_ctrl = out_valid ? main ctrl : 0.
- Events:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: push -> ONE, main<=in.
  - ONE, push&pop -> ONE, main<=in.
  - ONE, push&~pop -> TWO, skid<=in.
  - ONE, ~push&pop -> EMPTY.
  - TWO: push is impossible. pop -> ONE, main<=skid.
  - Otherwise the state and entries are held.
- hold=1:
  - No push, no pop; contents frozen.
  - out_valid=0, so a bubble with all-zero control is presented downstream.
  - Releasing hold re-presents the same head with no loss or duplication.
- flush=1:
  - Highest priority over push, pop and hold. Next state is EMPTY; any simultaneous input is discarded.
  - Main/skid data are retained; ctrl bits are cleared to 0.
  - out_valid=0 from the following cycle.
- Latency: one cycle from accepted input to out_valid when empty. Full throughput (one per cycle) in the ONE state with out_ready=1.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Reset mid-operation: immediately empties the stage regardless of hold/flush.

Optional Feature:
PIPE_STAGE_PERF_EN:
- Defined:
  - stall_cnt increments each cycle hold=1.
  - flush_cnt increments on flush=1 with state!=EMPTY.
  - bp_cnt increments each cycle out_valid&~out_ready.
  - All counters saturate at 2^CNT_W-1 (no wrap) and clear only on rst.
- Undefined: the counter registers are not built; stall_cnt, flush_cnt and bp_cnt are tied to 0. Handshake behaviour is identical.

Test Plan:
1. Reset then stream: rst pulse; in_valid=1 with data 0x1..0x5, ctrl=0x00FF, out_ready=1 -> out_valid rises 1 cycle after the first accept; outputs 0x1..0x5 on consecutive cycles; in_ready stays 1.
2. Backpressure: stream 0xA,0xB,0xC with out_ready=0 -> state TWO after 2 accepts; in_ready=0; 0xC held upstream. With out_ready=1 the order is 0xA,0xB,0xC; bp_cnt counts the stalled cycles (macro on).
3. Hazard hold: head=0x7 with ctrl=0x0003; hold=1 for 3 cycles -> out_valid=0, out_ctrl=0, in_ready=0. After release, 0x7 appears exactly once; stall_cnt=3.
4. Flush with entries: state TWO (0x10,0x11); flush=1 concurrent with in_valid=1 data 0x12 -> next cycle state EMPTY, out_valid=0, out_ctrl=0. 0x12 is dropped; flush_cnt=1. A flush while EMPTY leaves flush_cnt unchanged.
5. Flush+hold priority: hold=1 and flush=1 together -> stage empties. Releasing hold produces no stale output.
6. Async reset mid-stream: assert rst between clock edges in state TWO -> out_valid=0 and in_ready=1 immediately (hold=0); counters=0; saturation checked by forcing CNT_W=4 and holding 20 cycles -> stall_cnt=15.
